// File: rtl/guitar_btn_pkg.sv
// Shared types and default parameters for the guitar button conditioner.
package guitar_btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 10000;

endpackage

// File: rtl/guitar_btn_conditioner_if.sv
// Button bundle between the raw pad side and the game top level.
interface guitar_btn_conditioner_if #(
    parameter int NUM_BTN = 4
);

    logic               chip_select;
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;

    modport master (
        output chip_select,
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  chip_select,
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );

endinterface

// File: rtl/guitar_btn_conditioner_fsm.sv
// One button: synchroniser, saturating debounce counter, FSM and
// registered level / press / release outputs.
module btn_debounce_fsm
    import guitar_btn_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic n_rst,
    input  logic chip_select,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_sync;
    btn_state_t             state, state_d;
    logic [CW-1:0]          cnt, cnt_d, cnt_inc;
    logic                   enter_press, enter_idle;
    logic                   fresh_press, fresh_release;

    assign btn_sync = sync_q[SYNC_STAGES-1];
    assign cnt_inc  = (cnt == MAX) ? cnt : cnt + ONE;

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        enter_press = 1'b0;
        enter_idle  = 1'b0;
        if (chip_select) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (btn_sync) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = ONE;
                    end else begin
                        cnt_d = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_sync) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt == LAST) begin
                        state_d     = PRESSED;
                        cnt_d       = '0;
                        enter_press = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!btn_sync) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = ONE;
                    end else begin
                        cnt_d = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_sync) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt == LAST) begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        enter_idle = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs trail the state by one register; chip_select masks them at once.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            sync_q        <= '0;
            state         <= IDLE;
            cnt           <= '0;
            fresh_press   <= 1'b0;
            fresh_release <= 1'b0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], raw};
            state         <= state_d;
            cnt           <= cnt_d;
            fresh_press   <= enter_press;
            fresh_release <= enter_idle;
            level         <= ~chip_select &
                             ((state == PRESSED) || (state == RELEASE_WAIT));
            press_pulse   <= ~chip_select & fresh_press;
            release_pulse <= ~chip_select & fresh_release;
        end
    end

endmodule

// File: rtl/guitar_btn_conditioner.sv
// Four-button front end: one independent debounce FSM per button.
module guitar_btn_conditioner
    import guitar_btn_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input logic                     clk,
    input logic                     n_rst,
    guitar_btn_conditioner_if.slave bus
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce_fsm #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_fsm (
            .clk           (clk),
            .n_rst         (n_rst),
            .chip_select   (bus.chip_select),
            .raw           (bus.btn_raw[i]),
            .level         (bus.btn_level[i]),
            .press_pulse   (bus.btn_press[i]),
            .release_pulse (bus.btn_release[i])
        );
    end

endmodule

// File: doc/guitar_btn_conditioner.md
Name: guitar_btn_conditioner

Overview:
- Conditions the four raw push-button inputs before they reach the game top level (game input `button[3:0]`).
- Synchronises each asynchronous button and debounces it with a per-button FSM.
- Emits a clean level, a one-cycle press pulse and a one-cycle release pulse per button.
- Honours the design-wide `chip_select` gating: active-low enable, so the block is disabled when `chip_select` = 1.

Parameters:
- NUM_BTN, 4: number of independent buttons.
- SYNC_STAGES, 2: flip-flop synchroniser depth, >= 2.
- DEBOUNCE_CYCLES, 10000: consecutive stable synchronised samples required to accept a change, >= 2.

Ports:
- clk  input  1  system clock; the only clock.
- n_rst  input  1  reset, synchronous, active-high (1 = reset, sampled on rising clk).
- chip_select  input  1  0 = block active; 1 = block disabled.
- btn_raw  input  NUM_BTN  asynchronous raw button levels; 1 = pressed.
- btn_level  output  NUM_BTN  debounced level; 1 = held.
- btn_press  output  NUM_BTN  one-cycle pulse on accepted press.
- btn_release  output  NUM_BTN  one-cycle pulse on accepted release.

Behaviour:
- Reset (n_rst = 1 at a rising edge):
  - All synchroniser flops = 0.
  - All FSMs go to IDLE; counters = 0.
  - btn_level, btn_press, btn_release = 0 on the following cycle.
  - n_rst asserted mid-debounce aborts the debounce; no pulse is emitted.
- Synchroniser: btn_sync[i] is btn_raw[i] delayed by SYNC_STAGES flops. It runs whenever not in reset, regardless of chip_select.
- Per-button FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Counter width is $clog2(DEBOUNCE_CYCLES+1), saturating and never wrapping.
- IDLE:
  - btn_sync = 1 -> PRESS_WAIT, cnt = 1.
  - Otherwise stay, cnt = 0.
- PRESS_WAIT:
  - btn_sync = 0 -> IDLE, cnt = 0 (glitch rejected).
  - cnt == DEBOUNCE_CYCLES-1 with btn_sync = 1 -> PRESSED.
  - Otherwise cnt++.
- PRESSED:
  - btn_sync = 0 -> RELEASE_WAIT, cnt = 1.
- RELEASE_WAIT:
  - btn_sync = 1 -> PRESSED, cnt = 0.
  - cnt == DEBOUNCE_CYCLES-1 with btn_sync = 0 -> IDLE.
  - Otherwise cnt++.
- Outputs (all registered):
  - btn_level[i] = 1 in PRESSED and RELEASE_WAIT.
  - btn_press[i] is high exactly the cycle the FSM first enters PRESSED from PRESS_WAIT. Re-entry from RELEASE_WAIT gives no pulse.
  - btn_release[i] is high exactly the cycle of entry to IDLE from RELEASE_WAIT.
- Latency: clean raw rise sampled at edge 0 -> btn_press high for one cycle starting at edge SYNC_STAGES+DEBOUNCE_CYCLES. Release is symmetric.
- Bounce shorter than DEBOUNCE_CYCLES never changes btn_level and never pulses.
- Buttons are fully independent. Simultaneous presses on several buttons give simultaneous pulses in the same cycle.
- chip_select = 1:
  - Every FSM is forced to IDLE and counters cleared next edge.
  - All outputs = 0 from the next cycle.
  - No release pulse is generated by forced exit.
- chip_select returning to 0 while a button is held: the button restarts from IDLE and produces a fresh press after a full DEBOUNCE_CYCLES.
- The same cycle chip_select rises as a would-be pulse: chip_select wins, no pulse.

Decomposition:
- Package guitar_btn_pkg holds:
  - typedef enum logic [1:0] btn_state_t {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT}.
  - localparam DEF_SYNC_STAGES = 2.
  - localparam DEF_DEBOUNCE_CYCLES = 10000.
- Sub-module btn_debounce_fsm: one button, containing the synchroniser, counter, FSM and three output flops. The top instantiates it NUM_BTN times via generate.

Test Plan (DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2):
- Clean press: btn_raw[0] 0->1 at edge 0, held 20 cycles -> btn_press[0] high only during cycle 6; btn_level[0] = 1 from cycle 6; other bits stay 0.
- Bounce: btn_raw[1] toggles 1,0,1,1,0 then stays 0 -> btn_level[1], btn_press[1], btn_release[1] remain 0 throughout.
- Release with glitch: held button; raw drops for 2 cycles, returns high, later drops for good at edge 30 -> no release pulse for the glitch; btn_release one cycle at edge 36; btn_level falls at 36.
- Simultaneous: btn_raw = 4'b1010 at edge 0 -> btn_press = 4'b1010 for exactly cycle 6.
- chip_select: button held and pressed; set chip_select = 1 at edge 10 -> all outputs 0 from edge 11, no release pulse. Clear at edge 15 while still held -> btn_press pulse at edge 20 (15 + DEBOUNCE_CYCLES + 1).
- Reset mid-debounce: n_rst = 1 at edge 3 of a press -> no pulse. After reset deassert with raw held, the press pulse arrives SYNC_STAGES+DEBOUNCE_CYCLES edges later.
